// File: rtl/mc_control_fsm.sv
// Multi-cycle control FSM for a 16-bit, 16-opcode register machine.
// It sequences instruction fetch, execute, data memory access and branch resolution.
module mc_control_fsm #(
  parameter int unsigned    DW       = 16,
  parameter int unsigned    PCW      = 16,
  parameter logic [PCW-1:0] RESET_PC = '0
) (
  input  logic           clk,
  input  logic           reset,
  output logic           mem_req,
  output logic           mem_we,
  output logic [PCW-1:0] mem_addr,
  output logic [DW-1:0]  mem_wdata,
  input  logic [DW-1:0]  mem_rdata,
  input  logic           mem_ack,
  output logic [3:0]     reg_addr_a,
  output logic [3:0]     reg_addr_b,
  output logic [3:0]     reg_addr_c,
  output logic           reg_we,
  output logic           reg_wsel,
  output logic [3:0]     alu_op,
  output logic           im_en,
  output logic [DW-1:0]  imm,
  input  logic [DW-1:0]  rd_a,
  input  logic [DW-1:0]  alu_result,
  input  logic [DW-1:0]  status,
  output logic [PCW-1:0] pc
);

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpAddi = 4'd1;
  localparam logic [3:0] OpSub  = 4'd2;
  localparam logic [3:0] OpSubi = 4'd3;
  localparam logic [3:0] OpMult = 4'd4;
  localparam logic [3:0] OpSw   = 4'd5;
  localparam logic [3:0] OpLw   = 4'd6;
  localparam logic [3:0] OpLt   = 4'd7;
  localparam logic [3:0] OpNand = 4'd8;
  localparam logic [3:0] OpDiv  = 4'd9;
  localparam logic [3:0] OpMod  = 4'd10;
  localparam logic [3:0] OpLte  = 4'd11;
  localparam logic [3:0] OpBlt  = 4'd12;
  localparam logic [3:0] OpBge  = 4'd13;
  localparam logic [3:0] OpBeq  = 4'd14;
  localparam logic [3:0] OpJump = 4'd15;

  typedef enum logic [1:0] {StFetch, StExec, StMem, StBr} state_e;

  state_e         r_state, w_state_nxt;
  logic [15:0]    r_instr, w_instr_nxt;
  logic [PCW-1:0] r_pc, w_pc_nxt;

  logic [3:0]     w_opcode, w_op1, w_op2, w_op3;
  logic [11:0]    w_jmp;
  logic [PCW-1:0] w_pc_inc, w_br_off, w_jmp_off;
  logic [3:0]     w_alu_op;
  logic           w_is_reg, w_is_imm, w_is_mem, w_is_br, w_taken;

  assign w_opcode  = r_instr[15:12];
  assign w_op1     = r_instr[3:0];
  assign w_op2     = r_instr[7:4];
  assign w_op3     = r_instr[11:8];
  assign w_jmp     = r_instr[11:0];
  assign w_pc_inc  = r_pc + PCW'(1);
  assign w_br_off  = PCW'($signed(w_op1));
  assign w_jmp_off = PCW'($signed(w_jmp));
  assign pc        = r_pc;

  // BEQ compares via SUB, so equality shows up as a zero status word.
  assign w_taken = (w_opcode == OpBeq) ? (status == '0) : (status == DW'(1));

  always_comb begin
    w_alu_op = 4'd0;
    w_is_reg = 1'b0;
    w_is_imm = 1'b0;
    w_is_mem = 1'b0;
    w_is_br  = 1'b0;
    case (w_opcode)
      OpAdd:  w_is_reg = 1'b1;
      OpAddi: w_is_imm = 1'b1;
      OpSub:  begin w_is_reg = 1'b1; w_alu_op = 4'd1; end
      OpSubi: begin w_is_imm = 1'b1; w_alu_op = 4'd1; end
      OpMult: begin w_is_reg = 1'b1; w_alu_op = 4'd2; end
      OpSw:   w_is_mem = 1'b1;
      OpLw:   w_is_mem = 1'b1;
      OpLt:   begin w_is_reg = 1'b1; w_alu_op = 4'd6; end
      OpNand: begin w_is_reg = 1'b1; w_alu_op = 4'd3; end
      OpDiv:  begin w_is_reg = 1'b1; w_alu_op = 4'd4; end
      OpMod:  begin w_is_reg = 1'b1; w_alu_op = 4'd5; end
      OpLte:  begin w_is_reg = 1'b1; w_alu_op = 4'd7; end
      OpBlt:  begin w_is_br = 1'b1; w_alu_op = 4'd6; end
      OpBge:  begin w_is_br = 1'b1; w_alu_op = 4'd7; end
      OpBeq:  begin w_is_br = 1'b1; w_alu_op = 4'd1; end
      OpJump: w_alu_op = 4'd0;
      default: w_alu_op = 4'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StFetch;
      r_pc    <= RESET_PC;
      r_instr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    reg_addr_a  = 4'd0;
    reg_addr_b  = 4'd0;
    reg_addr_c  = 4'd0;
    reg_we      = 1'b0;
    reg_wsel    = 1'b0;
    alu_op      = 4'd0;
    im_en       = 1'b0;
    imm         = '0;
    unique case (r_state)
      StFetch: begin
        // Gated by reset so the request drops the instant reset is asserted.
        mem_req  = reset;
        mem_addr = r_pc;
        if (mem_ack) begin
          w_instr_nxt = 16'(mem_rdata);
          w_state_nxt = StExec;
        end
      end
      StExec: begin
        alu_op = w_alu_op;
        if (w_is_reg || w_is_imm) begin
          reg_addr_a  = w_is_imm ? 4'd0 : w_op1;
          reg_addr_b  = w_op2;
          reg_addr_c  = w_op3;
          reg_we      = 1'b1;
          im_en       = w_is_imm;
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = StFetch;
        end else if (w_is_mem) begin
          reg_addr_b  = w_op2;
          im_en       = 1'b1;
          w_state_nxt = StMem;
        end else if (w_is_br) begin
          reg_addr_a  = w_op3;
          reg_addr_b  = w_op2;
          w_state_nxt = StBr;
        end else begin
          w_pc_nxt    = r_pc + w_jmp_off;
          w_state_nxt = StFetch;
        end
      end
      StMem: begin
        alu_op     = w_alu_op;
        mem_req    = 1'b1;
        mem_addr   = PCW'(alu_result);
        reg_addr_b = w_op2;
        im_en      = 1'b1;
        if (w_opcode == OpSw) begin
          mem_we     = 1'b1;
          reg_addr_a = w_op3;
          mem_wdata  = rd_a;
        end else begin
          reg_addr_c = w_op3;
          reg_we     = mem_ack;
          reg_wsel   = mem_ack;
        end
        if (mem_ack) begin
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = StFetch;
        end
      end
      StBr: begin
        alu_op      = w_alu_op;
        reg_addr_a  = w_op3;
        reg_addr_b  = w_op2;
        w_pc_nxt    = w_taken ? (r_pc + w_br_off) : w_pc_inc;
        w_state_nxt = StFetch;
      end
      default: w_state_nxt = StFetch;
    endcase
    if (im_en) imm = DW'(w_op1);
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: the bench acts as memory, ALU and register
// file, and checks every cycle against an instruction-level reference model.
module tb_mc_control_fsm;
  localparam int unsigned DW    = 16;
  localparam int unsigned PCW   = 16;
  localparam logic [15:0] RstPc = 16'h0000;

  logic        clk, reset;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  reg_addr_a, reg_addr_b, reg_addr_c, alu_op;
  logic        reg_we, reg_wsel, im_en;
  logic [15:0] imm, rd_a, alu_result, status, pc;

  int total = 0;
  int bad   = 0;
  int m_pc  = 0;
  int alu_tbl [16] = '{0, 0, 1, 1, 2, 0, 0, 6, 3, 4, 5, 7, 6, 7, 1, 0};

  mc_control_fsm #(.DW(DW), .PCW(PCW), .RESET_PC(RstPc)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .reg_addr_a(reg_addr_a), .reg_addr_b(reg_addr_b), .reg_addr_c(reg_addr_c),
    .reg_we(reg_we), .reg_wsel(reg_wsel), .alu_op(alu_op), .im_en(im_en), .imm(imm),
    .rd_a(rd_a), .alu_result(alu_result), .status(status), .pc(pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0 register op, 1 immediate op, 2 load/store, 3 branch, 4 jump
  function automatic int op_class(input int op);
    case (op)
      1, 3:       return 1;
      5, 6:       return 2;
      12, 13, 14: return 3;
      15:         return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic int sext(input int v, input int bits);
    return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
  endfunction

  function automatic int wrap16(input int v);
    return (v + 131072) % 65536;
  endfunction

  task automatic apply_reset();
    @(negedge clk); #1 reset = 1'b0;
    @(posedge clk);
    @(negedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    m_pc    = int'(RstPc);
  endtask

  // Runs one instruction from its first FETCH cycle; entered and left just after a posedge.
  task automatic run_instr(input logic [15:0] ins, input int fw, input int mw,
                           input logic [15:0] ares, input logic [15:0] stat,
                           input logic [15:0] rdv);
    int op, o1, o2, o3, cl, npc, ea, eb, ec, ewe, eim, ealu;
    logic [15:0] old_pc;
    logic        lw, last, taken;
    op = int'(ins[15:12]); o1 = int'(ins[3:0]); o2 = int'(ins[7:4]); o3 = int'(ins[11:8]);
    cl = op_class(op);
    old_pc = 16'(m_pc);
    alu_result = ares; status = stat; rd_a = rdv;
    taken = (op == 14) ? (stat == 16'd0) : (stat == 16'd1);
    case (cl)
      3:       npc = taken ? m_pc + sext(o1, 4) : m_pc + 1;
      4:       npc = m_pc + sext(int'(ins[11:0]), 12);
      default: npc = m_pc + 1;
    endcase

    for (int k = 0; k <= fw; k++) begin
      mem_ack   = (k == fw);
      mem_rdata = (k == fw) ? ins : ~ins;
      @(negedge clk);
      total++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== old_pc || reg_we !== 1'b0 ||
          pc !== old_pc) begin
        bad++;
        $display("FAIL fetch[%0d] ins=%h: req=%b we=%b addr=%h reg_we=%b pc=%h, required 1 0 %h 0 %h",
                 k, ins, mem_req, mem_we, mem_addr, reg_we, pc, old_pc, old_pc);
      end
      @(posedge clk); #1;
    end

    mem_ack = 1'($urandom); mem_rdata = 16'($urandom);
    ea = 0; eb = 0; ec = 0; ewe = 0; eim = 0;
    case (cl)
      0: begin ea = o1; eb = o2; ec = o3; ewe = 1; end
      1: begin eb = o2; ec = o3; ewe = 1; eim = 1; end
      2: begin eb = o2; eim = 1; end
      3: begin ea = o3; eb = o2; end
      default: ;
    endcase
    ealu = alu_tbl[op];
    @(negedge clk);
    total++;
    if (reg_addr_a !== 4'(ea) || reg_addr_b !== 4'(eb) || reg_addr_c !== 4'(ec) ||
        reg_we !== 1'(ewe) || reg_wsel !== 1'b0 || im_en !== 1'(eim) ||
        imm !== (eim != 0 ? 16'(o1) : 16'd0) || alu_op !== 4'(ealu) || mem_req !== 1'b0 ||
        mem_we !== 1'b0 || mem_wdata !== 16'd0 || pc !== old_pc) begin
      bad++;
      $display("FAIL exec ins=%h: a=%h b=%h c=%h we=%b sel=%b im=%b imm=%h op=%h req=%b pc=%h, required a=%h b=%h c=%h we=%0d im=%0d op=%h pc=%h",
               ins, reg_addr_a, reg_addr_b, reg_addr_c, reg_we, reg_wsel, im_en, imm, alu_op,
               mem_req, pc, 4'(ea), 4'(eb), 4'(ec), ewe, eim, 4'(ealu), old_pc);
    end
    @(posedge clk); #1;

    if (cl == 2) begin
      lw = (op == 6);
      for (int k = 0; k <= mw; k++) begin
        last      = (k == mw);
        mem_ack   = last;
        mem_rdata = 16'($urandom);
        @(negedge clk);
        total++;
        if (mem_req !== 1'b1 || mem_we !== !lw || mem_addr !== ares || reg_addr_b !== 4'(o2) ||
            im_en !== 1'b1 || imm !== 16'(o1) || alu_op !== 4'd0 ||
            reg_addr_a !== (lw ? 4'd0 : 4'(o3)) || reg_addr_c !== (lw ? 4'(o3) : 4'd0) ||
            mem_wdata !== (lw ? 16'd0 : rdv) || reg_we !== (lw & last) ||
            reg_wsel !== (lw & last) || pc !== old_pc) begin
          bad++;
          $display("FAIL mem[%0d] ins=%h: req=%b we=%b addr=%h a=%h b=%h c=%h wd=%h rwe=%b sel=%b pc=%h, required addr=%h wd=%h rwe=%b",
                   k, ins, mem_req, mem_we, mem_addr, reg_addr_a, reg_addr_b, reg_addr_c,
                   mem_wdata, reg_we, reg_wsel, pc, ares, lw ? 16'd0 : rdv, lw & last);
        end
        @(posedge clk); #1;
      end
    end else if (cl == 3) begin
      mem_ack = 1'($urandom);
      @(negedge clk);
      total++;
      if (reg_addr_a !== 4'(o3) || reg_addr_b !== 4'(o2) || reg_addr_c !== 4'd0 ||
          im_en !== 1'b0 || reg_we !== 1'b0 || mem_req !== 1'b0 || alu_op !== 4'(ealu) ||
          pc !== old_pc) begin
        bad++;
        $display("FAIL br ins=%h: a=%h b=%h im=%b we=%b req=%b op=%h pc=%h, required a=%h b=%h op=%h pc=%h",
                 ins, reg_addr_a, reg_addr_b, im_en, reg_we, mem_req, alu_op, pc,
                 4'(o3), 4'(o2), 4'(ealu), old_pc);
      end
      @(posedge clk); #1;
    end

    mem_ack = 1'b0;
    m_pc    = wrap16(npc);
    total++;
    if (pc !== 16'(m_pc)) begin
      bad++;
      $display("FAIL pc_update ins=%h from %h stat=%h: pc=%h, required %h",
               ins, old_pc, stat, pc, 16'(m_pc));
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; mem_ack = 1'b0; mem_rdata = '0; rd_a = '0; alu_result = '0; status = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || reg_we !== 1'b0 || im_en !== 1'b0 ||
        pc !== RstPc) begin
      bad++;
      $display("FAIL reset_hold: req=%b we=%b rwe=%b im=%b pc=%h, required 0 0 0 0 %h",
               mem_req, mem_we, reg_we, im_en, pc, RstPc);
    end
    #1 reset = 1'b1;
    #1;
    total++;
    if (mem_req !== 1'b1 || mem_addr !== RstPc) begin
      bad++;
      $display("FAIL reset_release: req=%b addr=%h, required 1 %h", mem_req, mem_addr, RstPc);
    end
    @(posedge clk); #1;
    m_pc = int'(RstPc);
    // Reset dropped in the middle of an unacknowledged fetch.
    @(negedge clk); #1 reset = 1'b0;
    #1;
    total++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_fetch: req=%b we=%b, required 0 0", mem_req, mem_we);
    end
    @(negedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_alu_ops();
    run_instr(16'h0321, 0, 0, 16'h1234, 16'h0, 16'h0);
    run_instr(16'h1A5C, 0, 0, 16'h0, 16'h0, 16'h0);
    for (int op = 0; op < 16; op++)
      if (op_class(op) <= 1) run_instr({4'(op), 12'($urandom)}, 0, 0, 16'h0, 16'h0, 16'h0);
  endtask

  task automatic test_fetch_wait();
    run_instr(16'h2789, 3, 0, 16'h0, 16'h0, 16'h0);
  endtask

  task automatic test_load_store();
    run_instr(16'h6345, 0, 2, 16'h0040, 16'h0, 16'hBEEF);
    run_instr(16'h5A7F, 1, 0, 16'h0123, 16'h0, 16'hCAFE);
    run_instr(16'h5123, 0, 3, 16'hFFFF, 16'h0, 16'h5A5A);
  endtask

  task automatic test_branch();
    apply_reset();
    run_instr(16'hF010, 0, 0, 16'h0, 16'h0, 16'h0);
    run_instr(16'hE12E, 0, 0, 16'h0, 16'h0000, 16'h0);
    run_instr(16'hF002, 0, 0, 16'h0, 16'h0, 16'h0);
    run_instr(16'hE12E, 0, 0, 16'h0, 16'h0001, 16'h0);
    run_instr(16'hC347, 0, 0, 16'h0, 16'h0001, 16'h0);
    run_instr(16'hC349, 1, 0, 16'h0, 16'h0000, 16'h0);
    run_instr(16'hD56F, 0, 0, 16'h0, 16'h0001, 16'h0);
    run_instr(16'hD563, 0, 0, 16'h0, 16'h0002, 16'h0);
  endtask

  task automatic test_jump();
    apply_reset();
    run_instr(16'hF800, 0, 0, 16'h0, 16'h0, 16'h0);
    apply_reset();
    run_instr(16'hFFFF, 0, 0, 16'h0, 16'h0, 16'h0);
    run_instr(16'h0000, 0, 0, 16'h0, 16'h0, 16'h0);
  endtask

  task automatic test_reset_mid_mem();
    mem_ack = 1'b1; mem_rdata = 16'h5123; alu_result = 16'h0080; rd_a = 16'h7777;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0080) begin
      bad++;
      $display("FAIL pre_reset_mem: req=%b we=%b addr=%h, required 1 1 0080",
               mem_req, mem_we, mem_addr);
    end
    #1 reset = 1'b0;
    #1;
    total++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || pc !== RstPc) begin
      bad++;
      $display("FAIL reset_mid_mem: req=%b we=%b pc=%h, required 0 0 %h",
               mem_req, mem_we, pc, RstPc);
    end
    @(negedge clk); #1 reset = 1'b1;
    #1;
    total++;
    if (mem_req !== 1'b1 || mem_addr !== RstPc || mem_we !== 1'b0) begin
      bad++;
      $display("FAIL refetch_after_reset: req=%b addr=%h we=%b, required 1 %h 0",
               mem_req, mem_addr, mem_we, RstPc);
    end
    @(posedge clk); #1;
    m_pc = int'(RstPc);
    run_instr(16'h8123, 0, 0, 16'h0, 16'h0, 16'h0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++)
      run_instr(16'($urandom), 0, 0, 16'($urandom), 16'($urandom_range(0, 1)), 16'($urandom));
  endtask

  task automatic test_random();
    logic [15:0] st;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 2))
        0:       st = 16'd0;
        1:       st = 16'd1;
        default: st = 16'($urandom);
      endcase
      run_instr(16'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), 16'($urandom), st,
                16'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_fetch_wait();
    test_load_store();
    test_branch();
    test_jump();
    test_reset_mid_mem();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- DW, 16, data width of memory data, ALU result, status and register read data.
- PCW, 16, program-counter and memory-address width.
- RESET_PC, 0, PC value loaded at reset.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk in 1: single clock, all state on rising edge.
- reset in 1: asynchronous, active-low reset.
- mem_req out 1: memory request.
- mem_we out 1: memory write strobe.
- mem_addr out PCW: memory address.
- mem_wdata out DW: store data.
- mem_rdata in DW: read data, valid with mem_ack.
- mem_ack in 1: request completes this cycle.
- reg_addr_a / reg_addr_b / reg_addr_c out 4 each: read A, read B, write addresses.
- reg_we out 1: register write enable.
- reg_wsel out 1: write source, 0 = ALU, 1 = mem_rdata.
- alu_op out 4: ALU operation.
- im_en out 1: ALU B operand is imm.
- imm out DW: instr[3:0] zero-extended.
- rd_a in DW: register port A data.
- alu_result in DW: combinational ALU output.
- status in DW: ALU compare result.
- pc out PCW: current PC.

Function
REQ-003 Fields SHALL be: opcode = instr[15:12], op1 = instr[3:0], op2 = instr[7:4], op3 = instr[11:8], im = instr[3:0], jmp = instr[11:0].
REQ-004 Opcodes SHALL be: ADD 0, ADDI 1, SUB 2, SUBI 3, MULT 4, SW 5, LW 6, LT 7, NAND 8, DIV 9, MOD 10, LTE 11, BLT 12, BGE 13, BEQ 14, JUMP 15.
REQ-005 alu_op SHALL be: ADD/ADDI/SW/LW 0, SUB/SUBI/BEQ 1, MULT 2, NAND 3, DIV 4, MOD 5, LT/BLT 6, LTE/BGE 7.
REQ-006 The FSM SHALL have exactly four states: FETCH, EXEC, MEM and BR.
REQ-007 FETCH SHALL drive mem_req=1, mem_we=0 and mem_addr=pc, and SHALL hold these until mem_ack.
- On ack: instr <= mem_rdata and the FSM goes to EXEC.
- Without ack the FSM stays in FETCH with outputs stable.
REQ-008 EXEC, register ops (ADD, SUB, MULT, LT, NAND, DIV, MOD, LTE) SHALL drive a=op1, b=op2, c=op3, reg_we=1, reg_wsel=0 and im_en=0, then set pc <= pc+1 and go to FETCH.
REQ-009 EXEC, immediate ops (ADDI, SUBI) SHALL behave as REQ-008 except a=0 and im_en=1.
REQ-010 EXEC for SW/LW SHALL drive b=op2, im_en=1 and reg_we=0, then go to MEM.
REQ-011 MEM SHALL drive mem_req=1 and mem_addr=alu_result[PCW-1:0], holding b=op2 and im_en=1.
- SW: mem_we=1, a=op3, mem_wdata=rd_a.
- LW: mem_we=0, c=op3; reg_we=1 and reg_wsel=1 only in the ack cycle.
- On ack: pc <= pc+1 and the FSM goes to FETCH; otherwise it stays in MEM.
REQ-012 EXEC for BLT/BGE/BEQ SHALL drive a=op3, b=op2, im_en=0 and reg_we=0, then go to BR; BR SHALL hold the same outputs.
REQ-013 BR SHALL take the branch when status==1 (BLT, BGE) or status==0 (BEQ).
- Taken: pc <= pc + sign-extended im.
- Not taken: pc <= pc+1.
- Either way the FSM then goes to FETCH.
REQ-014 EXEC for JUMP SHALL set pc <= pc + sign-extended jmp and go to FETCH.
REQ-015 All PC arithmetic SHALL be modulo 2^PCW; offsets SHALL be sign-extended to PCW, and truncated when PCW < offset width.
REQ-016 Outputs not listed for a state SHALL be 0; no output SHALL ever be X.
REQ-017 mem_ack outside FETCH/MEM SHALL be ignored.
REQ-018 Throughput SHALL be as follows, with zero-wait ack:
- ALU and JUMP instructions: 2 cycles.
- SW, LW and branches: 3 cycles.
- Each wait cycle adds 1.

Reset
REQ-019 While reset is low the block SHALL asynchronously set state=FETCH, pc=RESET_PC and instr=0, with all strobes (mem_req excepted) at 0.
REQ-020 mem_req SHALL rise only in the first FETCH cycle after reset release.
REQ-021 Reset asserted mid-MEM or mid-FETCH SHALL drop mem_req and mem_we in the same cycle and abandon the transfer.

Verification
REQ-022 Directed scenarios:
- Reset, fetch 0x0321 with immediate ack -> EXEC: a=1, b=2, c=3, reg_we=1, alu_op=0; pc 0->1; next fetch at addr 1 two cycles after the first.
- Fetch ack delayed 3 cycles -> mem_req=1 and mem_addr=pc stable for 4 cycles; no reg_we pulse.
- LW 0x6345 with alu_result=0x0040 and ack after 2 waits -> MEM mem_addr=0x0040; single reg_we=1, reg_wsel=1, c=3 in the ack cycle; pc+1.
- BEQ 0xE12E at pc=0x0010: status=0 -> pc=0x000E; status=1 -> pc=0x0011.
- JUMP 0xF800 at pc=0x0000, PCW=16 -> pc=0xF800; JUMP 0xFFF at pc=0 -> pc=0xFFFF (wrap).
- Reset low during a SW MEM wait -> mem_req=0 and mem_we=0 immediately; after release pc=RESET_PC and a fetch at RESET_PC.
